game_controller: RTL and testbench
==================================

GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter ROUNDS, default 3: rounds per game, range 1..9.
REQ-002 Parameter INTERMISSION_S, default 5: seconds between rounds, range 1..15.
REQ-003 clk  in  1  50 MHz system clock; the only clock.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 start_n  in  1  KEY button, active-low, asynchronous to clk.
REQ-006 pause_n  in  1  KEY button, active-low, asynchronous to clk.
REQ-007 one_second_pulse  in  1  single-cycle tick from the countdown timer.
REQ-008 game_finished  in  1  level from the display timer, high while the round timer reads 00.
REQ-009 timer_restart  out  1  single-cycle pulse that reloads the round timer.
REQ-010 timer_run  out  1  level that enables round-timer countdown.
REQ-011 round_num  out  4  current round, binary, 0 when idle.
REQ-012 game_over  out  1  high in DONE.
REQ-013 HEX5  out  7  active-low seven-seg digit showing round_num, blank when 0.

Function
REQ-014 Each button passes through a 2-FF synchroniser plus a falling-edge detector, giving a 1-cycle press event on the 3rd rising clk edge after the pin goes low; holding the button yields one event.
REQ-015 game_finished is edge-detected with one register; fin_evt = game_finished & ~prev.
REQ-016 States: IDLE, RUN, PAUSE, INTERMISSION, DONE; the FSM acts on the clk edge after the event.
REQ-017 IDLE: start event -> RUN, round_num=1, timer_restart pulsed for one cycle.
REQ-018 RUN: fin_evt -> DONE if round_num==ROUNDS, otherwise INTERMISSION with gap counter = INTERMISSION_S; pause event -> PAUSE.
REQ-019 RUN with fin_evt and pause event in the same cycle: fin_evt wins and the pause is dropped.
REQ-020 PAUSE: pause event -> RUN; fin_evt is ignored; start event is ignored.
REQ-021 INTERMISSION: each one_second_pulse decrements the gap counter; when the counter is 0 -> RUN, round_num+1, timer_restart pulsed.
REQ-022 INTERMISSION: a start event skips the remaining gap with the same transition; the counter never wraps below 0.
REQ-023 DONE: start event -> RUN, round_num=1, timer_restart pulsed; game_over is held high until that transition.
REQ-024 timer_run=1 only in RUN, registered, so it is high on the same cycle as the state.
REQ-025 timer_restart is never asserted in consecutive cycles and never outside the transitions listed above.
REQ-026 round_num never exceeds ROUNDS; HEX5 is combinational from round_num through the decoder.

Reset
REQ-027 While rst=0: state IDLE; round_num=0; gap counter=0; timer_run=0; timer_restart=0; game_over=0; HEX5=7'h7F; synchroniser and edge registers cleared to the idle level (button registers 1, fin register 0).
REQ-028 Reset asserted mid-round aborts the round immediately with no timer_restart pulse; after release, only a start event leaves IDLE.

Structure
REQ-029 Shared package game_pkg holds the state enum, the 7-seg blank constant, and the digit pattern table.
REQ-030 One sub-module, seg7_decoder (4-bit in, 7-bit active-low out, 0..9 plus blank), is instantiated for HEX5; it is shared with the timer display.
REQ-031 Synchroniser and edge logic are inline; there are no further sub-modules.

Verification (ROUNDS=2, INTERMISSION_S=2)
REQ-032 Reset, then start_n low 10 cycles -> one timer_restart pulse 4 edges after the press, round_num=1, timer_run=1, HEX5 shows "1".
REQ-033 In round 1, game_finished rises -> INTERMISSION, timer_run=0; 2 one_second_pulses later -> timer_restart, round_num=2.
REQ-034 In round 2, game_finished rises -> DONE, game_over=1, round_num stays 2; start press -> round_num=1, game_over=0.
REQ-035 RUN with pause press, then game_finished toggled -> stays PAUSE; second pause press -> RUN, timer_run=1.
REQ-036 game_finished rise and pause event in the same cycle -> INTERMISSION, not PAUSE.
REQ-037 rst pulled low in INTERMISSION -> all outputs reset immediately; start_n held low through rst release -> no event until the button is released and pressed again.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and seven-segment tables for the game controller and its displays.
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_INTERMISSION,
        S_DONE
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low gfedcba patterns; the leftmost entry is digit 9, the rightmost digit 0.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg_pattern(input logic [3:0] value);
        if (value > 4'd9) begin
            return SEG_BLANK;
        end
        return SEG_DIGITS[value];
    endfunction

endpackage

// File: rtl/game_controller_if.sv
// Handshake between the game controller and the round timer.
interface game_controller_if;
    logic one_second_pulse;
    logic game_finished;
    logic timer_restart;
    logic timer_run;

    modport master (
        input  one_second_pulse,
        input  game_finished,
        output timer_restart,
        output timer_run
    );

    modport slave (
        output one_second_pulse,
        output game_finished,
        input  timer_restart,
        input  timer_run
    );
endinterface

// File: rtl/seg7_decoder.sv
// Binary digit to active-low seven-segment pattern; blank forces all segments off.
module seg7_decoder
    import game_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] seg
);
    assign seg = blank ? SEG_BLANK : seg_pattern(value);
endmodule

// File: rtl/game_controller.sv
// Round sequencing for a timed game: start/pause buttons, intermission gap, round display.
module game_controller
    import game_pkg::*;
#(
    parameter int ROUNDS         = 3,
    parameter int INTERMISSION_S = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_n,
    input  logic               pause_n,
    game_controller_if.master  tif,
    output logic [3:0]         round_num,
    output logic               game_over,
    output logic [6:0]         HEX5
);

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);
    localparam logic [3:0] GAP_LOAD   = 4'(INTERMISSION_S);

    logic [1:0] btn_n;
    logic [1:0] btn_evt;
    logic [2:0] arm_reg;
    logic       fin_prev_reg;
    logic       start_evt;
    logic       pause_evt;
    logic       fin_evt;

    state_t     state_reg;
    logic [3:0] round_reg;
    logic [3:0] gap_reg;
    logic       run_reg;
    logic       restart_reg;
    logic       over_reg;

    assign btn_n = {pause_n, start_n};

    // Button edges are only trusted once the pipeline holds real pin samples, so a
    // button held down across reset release must be let go before it can fire.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arm_reg <= 3'b000;
        end else begin
            arm_reg <= {arm_reg[1:0], 1'b1};
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic [1:0] sync_reg;
            logic       prev_reg;
            logic       evt_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync_reg <= 2'b11;
                    prev_reg <= 1'b1;
                    evt_reg  <= 1'b0;
                end else begin
                    sync_reg <= {sync_reg[0], btn_n[gi]};
                    prev_reg <= sync_reg[1];
                    evt_reg  <= arm_reg[2] & prev_reg & ~sync_reg[1];
                end
            end

            assign btn_evt[gi] = evt_reg;
        end
    endgenerate

    assign start_evt = btn_evt[0];
    assign pause_evt = btn_evt[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fin_prev_reg <= 1'b0;
        end else begin
            fin_prev_reg <= tif.game_finished;
        end
    end

    assign fin_evt = tif.game_finished & ~fin_prev_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= S_IDLE;
            round_reg   <= 4'd0;
            gap_reg     <= 4'd0;
            run_reg     <= 1'b0;
            restart_reg <= 1'b0;
            over_reg    <= 1'b0;
        end else begin
            restart_reg <= 1'b0;
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start_evt) begin
                        state_reg   <= S_RUN;
                        round_reg   <= 4'd1;
                        run_reg     <= 1'b1;
                        restart_reg <= 1'b1;
                        over_reg    <= 1'b0;
                    end
                end
                S_RUN: begin
                    // A round ending takes priority over a pause arriving in the same cycle.
                    if (fin_evt) begin
                        run_reg <= 1'b0;
                        if (round_reg == LAST_ROUND) begin
                            state_reg <= S_DONE;
                            over_reg  <= 1'b1;
                        end else begin
                            state_reg <= S_INTERMISSION;
                            gap_reg   <= GAP_LOAD;
                        end
                    end else if (pause_evt) begin
                        state_reg <= S_PAUSE;
                        run_reg   <= 1'b0;
                    end
                end
                S_PAUSE: begin
                    if (pause_evt) begin
                        state_reg <= S_RUN;
                        run_reg   <= 1'b1;
                    end
                end
                S_INTERMISSION: begin
                    if (start_evt || gap_reg == 4'd0) begin
                        state_reg   <= S_RUN;
                        round_reg   <= round_reg + 4'd1;
                        gap_reg     <= 4'd0;
                        run_reg     <= 1'b1;
                        restart_reg <= 1'b1;
                    end else if (tif.one_second_pulse) begin
                        gap_reg <= gap_reg - 4'd1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    round_reg <= 4'd0;
                    gap_reg   <= 4'd0;
                    run_reg   <= 1'b0;
                    over_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign tif.timer_run     = run_reg;
    assign tif.timer_restart = restart_reg;
    assign round_num         = round_reg;
    assign game_over         = over_reg;

    seg7_decoder u_hex5 (
        .value (round_reg),
        .blank (round_reg == 4'd0),
        .seg   (HEX5)
    );

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller with two rounds and a two-second intermission.
module tb_game_controller;

    logic       clk;
    logic       rst;
    logic       start_n;
    logic       pause_n;
    logic [3:0] round_num;
    logic       game_over;
    logic [6:0] HEX5;

    int total;
    int bad;

    game_controller_if tif ();

    game_controller #(
        .ROUNDS         (2),
        .INTERMISSION_S (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_n   (start_n),
        .pause_n   (pause_n),
        .tif       (tif),
        .round_num (round_num),
        .game_over (game_over),
        .HEX5      (HEX5)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Let the synchroniser see the released level, press, and stop on the edge the FSM reacts.
    task automatic press_start();
        start_n = 1'b1;
        repeat (3) tick();
        start_n = 1'b0;
        repeat (4) tick();
        start_n = 1'b1;
    endtask

    task automatic press_pause();
        pause_n = 1'b1;
        repeat (3) tick();
        pause_n = 1'b0;
        repeat (4) tick();
        pause_n = 1'b1;
    endtask

    task automatic finish_rise();
        tif.game_finished = 1'b1;
        tick();
    endtask

    task automatic second_pulse();
        tif.one_second_pulse = 1'b1;
        tick();
        tif.one_second_pulse = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        start_n = 1'b1;
        pause_n = 1'b1;
        tif.one_second_pulse = 1'b0;
        tif.game_finished    = 1'b0;

        repeat (2) tick();
        check("reset_round",   32'(round_num),         32'd0);
        check("reset_run",     32'(tif.timer_run),     32'd0);
        check("reset_restart", 32'(tif.timer_restart), 32'd0);
        check("reset_over",    32'(game_over),         32'd0);
        check("reset_hex",     32'(HEX5),              32'h7F);
        rst = 1'b1;
        repeat (2) tick();

        // Start held for ten cycles: restart on the 4th edge, only once.
        start_n = 1'b0;
        repeat (3) tick();
        check("start_edge3_restart", 32'(tif.timer_restart), 32'd0);
        tick();
        check("start_restart", 32'(tif.timer_restart), 32'd1);
        check("start_round",   32'(round_num),         32'd1);
        check("start_run",     32'(tif.timer_run),     32'd1);
        check("start_hex",     32'(HEX5),              32'h79);
        tick();
        check("restart_single", 32'(tif.timer_restart), 32'd0);
        repeat (5) tick();
        start_n = 1'b1;
        check("held_round",   32'(round_num),         32'd1);
        check("held_restart", 32'(tif.timer_restart), 32'd0);

        // Round 1 ends, intermission counts two seconds.
        finish_rise();
        check("inter_run",   32'(tif.timer_run), 32'd0);
        check("inter_round", 32'(round_num),     32'd1);
        tif.game_finished = 1'b0;
        second_pulse();
        tick();
        check("gap1_restart", 32'(tif.timer_restart), 32'd0);
        second_pulse();
        check("gap0_restart", 32'(tif.timer_restart), 32'd0);
        check("gap0_run",     32'(tif.timer_run),     32'd0);
        tick();
        check("round2_restart", 32'(tif.timer_restart), 32'd1);
        check("round2_round",   32'(round_num),         32'd2);
        check("round2_run",     32'(tif.timer_run),     32'd1);
        check("round2_hex",     32'(HEX5),              32'h24);
        tick();
        check("round2_restart_drop", 32'(tif.timer_restart), 32'd0);

        // Last round ends, then a new game.
        finish_rise();
        check("done_over",  32'(game_over),     32'd1);
        check("done_round", 32'(round_num),     32'd2);
        check("done_run",   32'(tif.timer_run), 32'd0);
        tif.game_finished = 1'b0;
        tick();
        press_start();
        check("restart_game_round",   32'(round_num),         32'd1);
        check("restart_game_over",    32'(game_over),         32'd0);
        check("restart_game_restart", 32'(tif.timer_restart), 32'd1);

        // Pause ignores finish and start; second pause resumes.
        press_pause();
        check("pause_run", 32'(tif.timer_run), 32'd0);
        finish_rise();
        tif.game_finished = 1'b0;
        tick();
        check("pause_fin_run",   32'(tif.timer_run), 32'd0);
        check("pause_fin_round", 32'(round_num),     32'd1);
        press_start();
        check("pause_start_run",     32'(tif.timer_run),     32'd0);
        check("pause_start_restart", 32'(tif.timer_restart), 32'd0);
        press_pause();
        check("resume_run",     32'(tif.timer_run),     32'd1);
        check("resume_restart", 32'(tif.timer_restart), 32'd0);

        // Finish and pause events land on the same edge: intermission wins.
        repeat (3) tick();
        pause_n = 1'b0;
        repeat (3) tick();
        tif.game_finished = 1'b1;
        tick();
        pause_n = 1'b1;
        tif.game_finished = 1'b0;
        check("simul_run", 32'(tif.timer_run), 32'd0);
        tick();
        second_pulse();
        second_pulse();
        tick();
        check("simul_restart", 32'(tif.timer_restart), 32'd1);
        check("simul_round",   32'(round_num),         32'd2);

        // Start skips the intermission gap.
        finish_rise();
        tif.game_finished = 1'b0;
        check("skip_pre_over", 32'(game_over), 32'd1);
        press_start();
        finish_rise();
        tif.game_finished = 1'b0;
        press_start();
        check("skip_restart", 32'(tif.timer_restart), 32'd1);
        check("skip_round",   32'(round_num),         32'd2);

        // Reach an intermission again, then reset in the middle of it.
        finish_rise();
        tif.game_finished = 1'b0;
        press_start();
        finish_rise();
        tif.game_finished = 1'b0;
        check("pre_reset_run",   32'(tif.timer_run), 32'd0);
        check("pre_reset_round", 32'(round_num),     32'd1);
        start_n = 1'b0;
        rst = 1'b0;
        #1;
        check("async_round",   32'(round_num),         32'd0);
        check("async_run",     32'(tif.timer_run),     32'd0);
        check("async_restart", 32'(tif.timer_restart), 32'd0);
        check("async_over",    32'(game_over),         32'd0);
        check("async_hex",     32'(HEX5),              32'h7F);
        repeat (3) tick();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("held_through_reset_restart", 32'(tif.timer_restart), 32'd0);
        end
        check("held_through_reset_round", 32'(round_num), 32'd0);
        start_n = 1'b1;
        press_start();
        check("repress_restart", 32'(tif.timer_restart), 32'd1);
        check("repress_round",   32'(round_num),         32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
